// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-side memory port arbiter: FSM states, requester IDs,
// and the byte-count encodings used by memory_access_ctrl.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // rw_mem_bytes carries (byte count - 1)
    localparam logic [2:0] BYTES_1 = 3'd0;
    localparam logic [2:0] BYTES_2 = 3'd1;
    localparam logic [2:0] BYTES_4 = 3'd3;
    localparam logic [2:0] BYTES_8 = 3'd7;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and load/store (D), plus the
// next value of the I-starvation counter for when a grant is actually taken.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                grant_o,
    output port_e               winner_o,
    output logic [STARVE_W-1:0] starve_cnt_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    always_comb begin
        grant_o      = i_req_i | d_req_i;
        winner_o     = PORT_D;
        starve_cnt_o = starve_cnt_i;
        // D wins ties until I has been passed over LIMIT times in a row
        if (i_req_i && (!d_req_i || starve_cnt_i == LIMIT)) begin
            winner_o     = PORT_I;
            starve_cnt_o = '0;
        end else if (d_req_i && i_req_i && starve_cnt_i < LIMIT) begin
            starve_cnt_o = starve_cnt_i + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory_access_ctrl port between instruction fetch (read-only)
// and the LSU; one transaction at a time, D priority with bounded I starvation.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [31:0]     i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [2:0]      d_bytes,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            r_mem_ena,
    output logic            w_mem_ena,
    output logic [XLEN-1:0] rw_mem_addr,
    output logic [2:0]      rw_mem_bytes,
    output logic [XLEN-1:0] w_mem_data,
    input  logic            mem_data_ready,
    input  logic [XLEN-1:0] mem_data
);

    arb_state_e          state_q, state_d;
    port_e               winner_q, winner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                r_ena_q, r_ena_d, w_ena_q, w_ena_d;
    logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]          bytes_q, bytes_d;
    logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [31:0]         i_rdata_q, i_rdata_d;
    logic [XLEN-1:0]     d_rdata_q, d_rdata_d;

    logic                pick_grant;
    port_e               pick_winner;
    logic [STARVE_W-1:0] pick_starve;
    logic [XLEN-1:0]     rdata_masked;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_q),
        .grant_o      (pick_grant),
        .winner_o     (pick_winner),
        .starve_cnt_o (pick_starve)
    );

    // Load data is zero-extended above the latched byte count
    always_comb begin
        rdata_masked = '0;
        for (int b = 0; b < XLEN / 8; b++) begin
            if (b <= int'(bytes_q)) rdata_masked[b*8 +: 8] = mem_data[b*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        starve_d  = starve_q;
        r_ena_d   = r_ena_q;
        w_ena_d   = w_ena_q;
        addr_d    = addr_q;
        bytes_d   = bytes_q;
        wdata_d   = wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    winner_d = pick_winner;
                    starve_d = pick_starve;
                    state_d  = BUSY;
                    if (pick_winner == PORT_I) begin
                        r_ena_d = 1'b1;
                        addr_d  = i_addr;
                        bytes_d = BYTES_4;
                    end else begin
                        r_ena_d = ~d_we;
                        w_ena_d = d_we;
                        addr_d  = d_addr;
                        bytes_d = d_bytes;
                        wdata_d = d_wdata;
                    end
                end
            end
            BUSY: begin
                if (mem_data_ready) begin
                    r_ena_d = 1'b0;
                    w_ena_d = 1'b0;
                    state_d = RESP;
                    if (winner_q == PORT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_data[31:0];
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rdata_masked;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            winner_q  <= PORT_I;
            starve_q  <= '0;
            r_ena_q   <= 1'b0;
            w_ena_q   <= 1'b0;
            addr_q    <= '0;
            bytes_q   <= '0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            starve_q  <= starve_d;
            r_ena_q   <= r_ena_d;
            w_ena_q   <= w_ena_d;
            addr_q    <= addr_d;
            bytes_q   <= bytes_d;
            wdata_q   <= wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign r_mem_ena    = r_ena_q;
    assign w_mem_ena    = w_ena_q;
    assign rw_mem_addr  = addr_q;
    assign rw_mem_bytes = bytes_q;
    assign w_mem_data   = wdata_q;
    assign i_ack        = i_ack_q;
    assign i_rdata      = i_rdata_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, masked loads, starvation
// ordering, mid-transaction reset and spurious ready / field changes in BUSY.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_data_ready;
    logic [63:0] i_addr, d_addr, d_wdata, mem_data;
    logic [2:0]  d_bytes;
    logic        i_ack, d_ack, r_mem_ena, w_mem_ena;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, rw_mem_addr, w_mem_data;
    logic [2:0]  rw_mem_bytes;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_bytes(d_bytes),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .r_mem_ena(r_mem_ena), .w_mem_ena(w_mem_ena), .rw_mem_addr(rw_mem_addr),
        .rw_mem_bytes(rw_mem_bytes), .w_mem_data(w_mem_data),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until an enable rises; acks must stay low meanwhile
    task automatic wait_grant(output bit is_i);
        bit seen = 0;
        is_i = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (r_mem_ena || w_mem_ena) seen = 1;
            else chk("no_ack_idle", {62'd0, i_ack, d_ack}, 64'd0);
        end
        chk("grant_seen", {63'd0, seen}, 64'd1);
        chk("ena_onehot", {63'd0, r_mem_ena & w_mem_ena}, 64'd0);
        is_i = (rw_mem_addr == i_addr) && i_req;
    endtask

    // Hold BUSY for 'delay' cycles after the enable, then pulse ready
    task automatic finish_txn(input int delay, input logic [63:0] data, input logic [63:0] exp_addr);
        for (int k = 0; k < delay; k++) begin
            chk("busy_hold", {61'd0, r_mem_ena | w_mem_ena, i_ack, d_ack}, 64'd4);
            chk("busy_addr", rw_mem_addr, exp_addr);
            step();
        end
        mem_data_ready = 1'b1;
        mem_data       = data;
        step();
        mem_data_ready = 1'b0;
        mem_data       = '0;
        chk("ena_drop", {62'd0, r_mem_ena, w_mem_ena}, 64'd0);
    endtask

    logic [63:0] load_exp [4];
    logic [2:0]  load_bytes [4];

    initial begin
        bit is_i;
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_data_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_data = '0; d_bytes = '0;
        repeat (3) step();

        // reset values
        chk("rst_ena", {62'd0, r_mem_ena, w_mem_ena}, 64'd0);
        chk("rst_ack", {62'd0, i_ack, d_ack}, 64'd0);
        chk("rst_addr", rw_mem_addr, 64'd0);
        chk("rst_bytes", {61'd0, rw_mem_bytes}, 64'd0);
        chk("rst_wdata", w_mem_data, 64'd0);
        chk("rst_irdata", {32'd0, i_rdata}, 64'd0);
        chk("rst_drdata", d_rdata, 64'd0);
        rst = 1'b0;

        // single fetch, ready 10 cycles after enable
        i_req = 1; i_addr = 64'h1000;
        wait_grant(is_i);
        chk("f_rena", {62'd0, r_mem_ena, w_mem_ena}, 64'd2);
        chk("f_addr", rw_mem_addr, 64'h1000);
        chk("f_bytes", {61'd0, rw_mem_bytes}, 64'd3);
        finish_txn(10, 64'hCAFEF00D_00000013, 64'h1000);
        chk("f_ack", {62'd0, i_ack, d_ack}, 64'd2);
        chk("f_rdata", {32'd0, i_rdata}, 64'h13);
        i_req = 0;
        step();
        chk("f_ack_once", {62'd0, i_ack, d_ack}, 64'd0);

        // 8-byte store
        d_req = 1; d_we = 1; d_addr = 64'h2008; d_bytes = 3'd7; d_wdata = 64'h1122334455667788;
        wait_grant(is_i);
        chk("s_ena", {62'd0, r_mem_ena, w_mem_ena}, 64'd1);
        chk("s_addr", rw_mem_addr, 64'h2008);
        chk("s_bytes", {61'd0, rw_mem_bytes}, 64'd7);
        chk("s_wdata", w_mem_data, 64'h1122334455667788);
        finish_txn(3, 64'd0, 64'h2008);
        chk("s_ack", {62'd0, i_ack, d_ack}, 64'd1);
        d_req = 0; d_we = 0;
        step();
        chk("s_ack_once", {62'd0, i_ack, d_ack}, 64'd0);

        // loads of every legal width, zero-extended
        load_bytes[0] = 3'd0; load_exp[0] = 64'h10;
        load_bytes[1] = 3'd1; load_exp[1] = 64'h3210;
        load_bytes[2] = 3'd3; load_exp[2] = 64'h76543210;
        load_bytes[3] = 3'd7; load_exp[3] = 64'hFEDCBA9876543210;
        for (int v = 0; v < 4; v++) begin
            d_req = 1; d_we = 0; d_addr = 64'h3000 + 64'(v); d_bytes = load_bytes[v];
            wait_grant(is_i);
            chk("l_ena", {62'd0, r_mem_ena, w_mem_ena}, 64'd2);
            chk("l_bytes", {61'd0, rw_mem_bytes}, {61'd0, load_bytes[v]});
            finish_txn(2, 64'hFEDCBA9876543210, 64'h3000 + 64'(v));
            chk("l_ack", {62'd0, i_ack, d_ack}, 64'd1);
            chk("l_rdata", d_rdata, load_exp[v]);
            d_req = 0;
            step();
        end
        d_req = 1; d_bytes = 3'd1; d_addr = 64'h3100;
        wait_grant(is_i);
        finish_txn(1, 64'hFFFFFFFFFFFFABCD, 64'h3100);
        chk("l2_rdata", d_rdata, 64'h000000000000ABCD);
        d_req = 0;
        step();

        // both held: D,D,D,D,I repeating
        i_req = 1; i_addr = 64'h1000;
        d_req = 1; d_we = 0; d_addr = 64'h2008; d_bytes = 3'd7;
        for (int g = 0; g < 10; g++) begin
            bit exp_i;
            exp_i = (g == 4 || g == 9);
            wait_grant(is_i);
            chk($sformatf("starve_order%0d", g), {63'd0, is_i}, {63'd0, exp_i});
            finish_txn(1, 64'h0000000100000002, exp_i ? 64'h1000 : 64'h2008);
            chk($sformatf("starve_ack%0d", g), {62'd0, i_ack, d_ack}, exp_i ? 64'd2 : 64'd1);
            if (g == 9) begin
                i_req = 0; d_req = 0;
            end
        end
        step();
        chk("starve_idle", {60'd0, i_ack, d_ack, r_mem_ena, w_mem_ena}, 64'd0);

        // reset during BUSY aborts without ack
        i_req = 1; i_addr = 64'h4000;
        wait_grant(is_i);
        step(); step();
        rst = 1; i_req = 0;
        step();
        rst = 0;
        chk("abort_ena", {62'd0, r_mem_ena, w_mem_ena}, 64'd0);
        chk("abort_addr", rw_mem_addr, 64'd0);
        mem_data_ready = 1; mem_data = 64'h55;
        step();
        mem_data_ready = 0;
        chk("abort_noack", {62'd0, i_ack, d_ack}, 64'd0);
        step();
        chk("abort_noack2", {62'd0, i_ack, d_ack}, 64'd0);
        i_req = 1; i_addr = 64'h4004;
        wait_grant(is_i);
        chk("fresh_addr", rw_mem_addr, 64'h4004);
        finish_txn(4, 64'h00000000DEADBEEF, 64'h4004);
        chk("fresh_ack", {62'd0, i_ack, d_ack}, 64'd2);
        chk("fresh_rdata", {32'd0, i_rdata}, 64'hDEADBEEF);
        i_req = 0;
        step();

        // spurious ready in IDLE, then request fields changing in BUSY
        mem_data_ready = 1; mem_data = 64'h77;
        step();
        mem_data_ready = 0;
        chk("spur_idle", {60'd0, i_ack, d_ack, r_mem_ena, w_mem_ena}, 64'd0);
        step();
        chk("spur_idle2", {60'd0, i_ack, d_ack, r_mem_ena, w_mem_ena}, 64'd0);
        d_req = 1; d_we = 0; d_addr = 64'h5000; d_bytes = 3'd3;
        wait_grant(is_i);
        d_addr = 64'hDEAD; d_bytes = 3'd0; d_we = 1;
        finish_txn(3, 64'h1234567887654321, 64'h5000);
        chk("mid_bytes_held", d_rdata, 64'h87654321);
        chk("mid_ack", {62'd0, i_ack, d_ack}, 64'd1);
        d_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
